// File: rtl/mnist_lut_eval_sequencer.sv
// Evaluation sequencer for the MNIST sparse-LUT classifier: streams labelled samples
// into the network, reduces returned votes to an argmax class and keeps accuracy counters.
module mnist_lut_eval_sequencer #(
  parameter int USER_WIDTH  = 8,
  parameter int INPUT_WIDTH = 784,
  parameter int CLASS_NUM   = 10,
  parameter int CHANNEL_NUM = 7,
  parameter int ADDR_WIDTH  = 14,
  parameter int TIMEOUT     = 4096
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              cke_i,
  input  logic                              start_i,
  input  logic [ADDR_WIDTH:0]               num_samples_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              error_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic                              mem_rd_o,
  input  logic [USER_WIDTH+INPUT_WIDTH-1:0] mem_rdata_i,
  output logic [USER_WIDTH:0]               net_in_user_o,
  output logic [INPUT_WIDTH-1:0]            net_in_data_o,
  output logic                              net_in_valid_o,
  input  logic [USER_WIDTH:0]               net_out_user_i,
  input  logic [CLASS_NUM*CHANNEL_NUM-1:0]  net_out_data_i,
  input  logic                              net_out_valid_i,
  output logic                              result_valid_o,
  output logic [USER_WIDTH-1:0]             result_class_o,
  output logic [USER_WIDTH-1:0]             result_label_o,
  output logic                              result_match_o,
  output logic [31:0]                       result_total_o,
  output logic [31:0]                       result_ok_o
);

  localparam int SUM_W  = $clog2(CHANNEL_NUM + 1);
  localparam int SUMS_W = CLASS_NUM * SUM_W;
  localparam int TO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Per-class vote count: bit j*CLASS_NUM+i is channel j voting for class i.
  function automatic logic [SUMS_W-1:0] vote_sums(input logic [CLASS_NUM*CHANNEL_NUM-1:0] votes);
    logic [SUMS_W-1:0] sums;
    logic [SUM_W-1:0]  acc;
    sums = '0;
    for (int i = 0; i < CLASS_NUM; i++) begin
      acc = '0;
      for (int j = 0; j < CHANNEL_NUM; j++) begin
        acc = acc + SUM_W'(votes[j*CLASS_NUM+i]);
      end
      sums[i*SUM_W +: SUM_W] = acc;
    end
    return sums;
  endfunction

  // Returns {any_vote, class}; strict compare keeps the lowest index on ties.
  function automatic logic [USER_WIDTH:0] argmax(input logic [SUMS_W-1:0] sums);
    logic [SUM_W-1:0]      best;
    logic [USER_WIDTH-1:0] idx;
    logic [USER_WIDTH:0]   res;
    best = sums[SUM_W-1:0];
    idx  = '0;
    for (int i = 1; i < CLASS_NUM; i++) begin
      if (sums[i*SUM_W +: SUM_W] > best) begin
        best = sums[i*SUM_W +: SUM_W];
        idx  = USER_WIDTH'(i);
      end else begin
        best = best;
      end
    end
    if (best == '0) begin
      res = {1'b0, {USER_WIDTH{1'b1}}};
    end else begin
      res = {1'b1, idx};
    end
    return res;
  endfunction

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH:0]    n_q, n_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   rd_q, rd_d;
  logic                   in_valid_q, in_valid_d;
  logic                   in_last_q, in_last_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   error_q, error_d;
  logic [31:0]            total_q, total_d;
  logic [31:0]            ok_q, ok_d;
  logic                   vote_valid_q, vote_valid_d;
  logic [USER_WIDTH:0]    vote_user_q, vote_user_d;
  logic [SUMS_W-1:0]      vote_sums_q, vote_sums_d;
  logic                   res_valid_q, res_valid_d;
  logic                   res_last_q, res_last_d;
  logic [USER_WIDTH-1:0]  res_class_q, res_class_d;
  logic [USER_WIDTH-1:0]  res_label_q, res_label_d;
  logic                   res_match_q, res_match_d;

  logic                   addr_is_last_s;
  logic                   run_s;
  logic [USER_WIDTH:0]    argmax_s;

  assign addr_is_last_s = ({1'b0, addr_q} == (n_q - (ADDR_WIDTH+1)'(1)));
  assign run_s          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign argmax_s       = argmax(vote_sums_q);

  // Next-state logic for the sequencer FSM, pipeline stages and counters.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    to_cnt_d     = to_cnt_q;
    error_d      = error_q;
    total_d      = total_q;
    ok_d         = ok_q;
    in_valid_d   = rd_q;
    in_last_d    = rd_q && addr_is_last_s;
    vote_valid_d = net_out_valid_i;
    vote_user_d  = net_out_valid_i ? net_out_user_i : '0;
    vote_sums_d  = net_out_valid_i ? vote_sums(net_out_data_i) : '0;
    res_valid_d  = vote_valid_q;
    res_last_d   = res_last_q;
    res_class_d  = res_class_q;
    res_label_d  = res_label_q;
    res_match_d  = res_match_q;

    if (vote_valid_q) begin
      res_last_d  = vote_user_q[USER_WIDTH];
      res_class_d = argmax_s[USER_WIDTH-1:0];
      res_label_d = vote_user_q[USER_WIDTH-1:0];
      res_match_d = argmax_s[USER_WIDTH] && (argmax_s[USER_WIDTH-1:0] == vote_user_q[USER_WIDTH-1:0]);
    end else begin
      res_last_d = res_last_q;
    end

    // Results seen outside a run are still reported but never counted.
    if (res_valid_q && run_s) begin
      total_d = total_q + 32'd1;
      ok_d    = ok_q + {31'd0, res_match_q};
    end else begin
      total_d = total_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          n_d      = num_samples_i;
          addr_d   = '0;
          total_d  = 32'd0;
          ok_d     = 32'd0;
          error_d  = 1'b0;
          to_cnt_d = '0;
          if (num_samples_i != '0) begin
            state_d = S_ISSUE;
            rd_d    = 1'b1;
          end else begin
            state_d = S_DONE;
            rd_d    = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_ISSUE: begin
        if (addr_is_last_s) begin
          state_d  = S_DRAIN;
          rd_d     = 1'b0;
          to_cnt_d = '0;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (res_valid_q && res_last_q) begin
          state_d = S_DONE;
          error_d = 1'b0;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and pipeline registers; everything holds while cke_i is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      in_valid_q   <= 1'b0;
      in_last_q    <= 1'b0;
      to_cnt_q     <= '0;
      error_q      <= 1'b0;
      total_q      <= 32'd0;
      ok_q         <= 32'd0;
      vote_valid_q <= 1'b0;
      vote_user_q  <= '0;
      vote_sums_q  <= '0;
      res_valid_q  <= 1'b0;
      res_last_q   <= 1'b0;
      res_class_q  <= '0;
      res_label_q  <= '0;
      res_match_q  <= 1'b0;
    end else if (cke_i) begin
      state_q      <= state_d;
      n_q          <= n_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      in_valid_q   <= in_valid_d;
      in_last_q    <= in_last_d;
      to_cnt_q     <= to_cnt_d;
      error_q      <= error_d;
      total_q      <= total_d;
      ok_q         <= ok_d;
      vote_valid_q <= vote_valid_d;
      vote_user_q  <= vote_user_d;
      vote_sums_q  <= vote_sums_d;
      res_valid_q  <= res_valid_d;
      res_last_q   <= res_last_d;
      res_class_q  <= res_class_d;
      res_label_q  <= res_label_d;
      res_match_q  <= res_match_d;
    end
  end

  assign busy_o         = run_s;
  assign done_o         = (state_q == S_DONE);
  assign error_o        = error_q;
  assign mem_addr_o     = addr_q;
  assign mem_rd_o       = rd_q;
  assign net_in_valid_o = in_valid_q;
  // Memory data arrives the cycle after the read strobe, so it is forwarded through a valid gate.
  assign net_in_data_o  = in_valid_q ? mem_rdata_i[INPUT_WIDTH-1:0] : '0;
  assign net_in_user_o  = in_valid_q ? {in_last_q, mem_rdata_i[INPUT_WIDTH +: USER_WIDTH]} : '0;
  assign result_valid_o = res_valid_q;
  assign result_class_o = res_class_q;
  assign result_label_o = res_label_q;
  assign result_match_o = res_match_q;
  assign result_total_o = total_q;
  assign result_ok_o    = ok_q;

endmodule

// File: tb/tb_mnist_lut_eval_sequencer.sv
// Bench for mnist_lut_eval_sequencer: sample memory, 3-cycle network model that forwards
// image bits [69:0] as votes, and a scoreboard fed from a per-sample reference model.
module tb_mnist_lut_eval_sequencer;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         cke_i;
  logic         start_i;
  logic [14:0]  num_samples_i;
  logic         busy_o, done_o, error_o;
  logic [13:0]  mem_addr_o;
  logic         mem_rd_o;
  logic [791:0] mem_rdata_i;
  logic [8:0]   net_in_user_o;
  logic [783:0] net_in_data_o;
  logic         net_in_valid_o;
  logic [8:0]   net_out_user_i;
  logic [69:0]  net_out_data_i;
  logic         net_out_valid_i;
  logic         result_valid_o;
  logic [7:0]   result_class_o, result_label_o;
  logic         result_match_o;
  logic [31:0]  result_total_o, result_ok_o;

  mnist_lut_eval_sequencer #(.TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cke_i(cke_i), .start_i(start_i),
    .num_samples_i(num_samples_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_rdata_i(mem_rdata_i),
    .net_in_user_o(net_in_user_o), .net_in_data_o(net_in_data_o), .net_in_valid_o(net_in_valid_o),
    .net_out_user_i(net_out_user_i), .net_out_data_i(net_out_data_i), .net_out_valid_i(net_out_valid_i),
    .result_valid_o(result_valid_o), .result_class_o(result_class_o), .result_label_o(result_label_o),
    .result_match_o(result_match_o), .result_total_o(result_total_o), .result_ok_o(result_ok_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { bit [7:0] cls; bit [7:0] lbl; bit m; } res_t;

  int         vectors = 0;
  int         miscompares = 0;
  logic [791:0] mem [64];
  bit [7:0]   s_label [64];
  bit [783:0] s_img [64];
  res_t       exp_q [$];
  int         run_n = 0;
  int         exp_total = 0, exp_ok = 0;
  bit         drop_last = 1'b0;
  int         exp_addr = 0, in_idx = 0;

  // Sample memory: synchronous read, one cycle latency.
  always @(posedge clk) begin
    if (cke_i && mem_rd_o) mem_rdata_i <= mem[mem_addr_o[5:0]];
  end

  // Network model: 3-cycle pipe, optionally losing the sample tagged last.
  logic       pv [3];
  logic [8:0] pu [3];
  logic [69:0] pd [3];
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 3; i++) begin pv[i] <= 1'b0; pu[i] <= '0; pd[i] <= '0; end
    end else if (cke_i) begin
      pv[0] <= net_in_valid_o && !(drop_last && net_in_user_o[8]);
      pu[0] <= net_in_user_o;
      pd[0] <= net_in_data_o[69:0];
      for (int i = 1; i < 3; i++) begin pv[i] <= pv[i-1]; pu[i] <= pu[i-1]; pd[i] <= pd[i-1]; end
    end
  end
  assign net_out_valid_i = pv[2];
  assign net_out_user_i  = pu[2];
  assign net_out_data_i  = pd[2];

  // Reference classification: count votes per class, highest count wins, first index on ties.
  function automatic bit [7:0] ref_class(input bit [69:0] v);
    int cnt [10];
    int best;
    bit [7:0] c;
    best = 0;
    c = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      cnt[k] = 0;
      for (int ch = 0; ch < 7; ch++) cnt[k] += int'(v[ch*10+k]);
      if (cnt[k] > best) begin best = cnt[k]; c = 8'(k); end
    end
    return c;
  endfunction

  // Monitor: every transfer that the next clock edge will consume is checked here.
  always @(negedge clk) begin
    if (rst_ni && cke_i) begin
      if (start_i && !busy_o) begin exp_addr = 0; in_idx = 0; end
      if (mem_rd_o) begin
        vectors++;
        if (exp_addr >= run_n || mem_addr_o !== 14'(exp_addr)) begin
          miscompares++;
          $display("FAIL mem_addr: got %0d, expected %0d (run of %0d)", mem_addr_o, exp_addr, run_n);
        end
        exp_addr++;
      end
      if (net_in_valid_o) begin
        vectors++;
        if (in_idx >= run_n ||
            {net_in_user_o, net_in_data_o} !== {(in_idx == run_n - 1), s_label[in_idx], s_img[in_idx]}) begin
          miscompares++;
          $display("FAIL net_in[%0d]: user got %h, expected last=%0d label=%0d", in_idx, net_in_user_o,
                   (in_idx == run_n - 1), s_label[in_idx]);
        end
        in_idx++;
      end
      if (result_valid_o) begin
        res_t r;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL result: unexpected result class=%0d label=%0d", result_class_o, result_label_o);
        end else begin
          r = exp_q.pop_front();
          if ({result_class_o, result_label_o, result_match_o} !== {r.cls, r.lbl, r.m}) begin
            miscompares++;
            $display("FAIL result: got class=%0d label=%0d match=%0d, expected class=%0d label=%0d match=%0d",
                     result_class_o, result_label_o, result_match_o, r.cls, r.lbl, r.m);
          end
        end
      end
    end
  end

  task automatic gen_sample(input int k, input bit [7:0] lbl, input bit [69:0] votes);
    bit [783:0] img;
    for (int b = 70; b < 784; b++) img[b] = 1'($urandom_range(0, 1));
    img[69:0] = votes;
    s_label[k] = lbl;
    s_img[k] = img;
  endtask

  function automatic bit [69:0] rand_votes(input bit [7:0] lbl);
    bit [69:0] v;
    int mode;
    v = '0;
    mode = $urandom_range(0, 7);
    if (mode != 0) for (int b = 0; b < 70; b++) v[b] = ($urandom_range(0, 3) == 0);
    if (mode >= 4 && lbl < 10) for (int ch = 0; ch < 7; ch++) v[ch*10+lbl] = 1'b1;
    return v;
  endfunction

  function automatic bit [69:0] label_votes(input int lbl);
    bit [69:0] v;
    v = '0;
    for (int ch = 0; ch < 7; ch++) v[ch*10+lbl] = 1'b1;
    return v;
  endfunction

  // Loads memory and builds the expected result stream and final counters.
  task automatic load_run(input int n, input bit drop);
    res_t r;
    run_n = n;
    drop_last = drop;
    exp_q.delete();
    exp_total = 0;
    exp_ok = 0;
    for (int k = 0; k < n; k++) begin
      mem[k] = {s_label[k], s_img[k]};
      if (!(drop && k == n - 1)) begin
        r.cls = ref_class(s_img[k][69:0]);
        r.lbl = s_label[k];
        r.m   = (r.cls != 8'hFF) && (r.cls == r.lbl);
        exp_q.push_back(r);
        exp_total++;
        exp_ok += int'(r.m);
      end
    end
  endtask

  // Start pulse; returns 1 time unit into cycle 1 (the cycle after the accepting edge).
  task automatic kick(input int n);
    @(posedge clk); #1;
    num_samples_i = 15'(n);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit tog, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done_o) begin got = 1'b1; break; end
      @(posedge clk); #1;
      if (tog) cke_i = ~cke_i;
    end
    cke_i = 1'b1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; cke_i = 1'b1; start_i = 1'b0; num_samples_i = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ((|{busy_o, done_o, error_o, mem_rd_o, mem_addr_o, net_in_valid_o, net_in_user_o, net_in_data_o,
           result_valid_o, result_class_o, result_label_o, result_match_o, result_total_o, result_ok_o}) !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: outputs not all zero (busy=%b done=%b addr=%0d total=%0d)",
               busy_o, done_o, mem_addr_o, result_total_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_identity;
    bit got;
    int lbls [4] = '{3, 7, 0, 9};
    for (int k = 0; k < 4; k++) gen_sample(k, 8'(lbls[k]), label_votes(lbls[k]));
    load_run(4, 1'b0);
    kick(4);
    vectors++;
    if ({busy_o, mem_rd_o, mem_addr_o} !== {1'b1, 1'b1, 14'd0}) begin
      miscompares++;
      $display("FAIL first_issue: busy=%b rd=%b addr=%0d, expected 1 1 0", busy_o, mem_rd_o, mem_addr_o);
    end
    for (int cyc = 2; cyc <= 11; cyc++) begin
      @(posedge clk); #1;
      if (cyc <= 4) begin
        vectors++;
        if ({mem_rd_o, mem_addr_o} !== {1'b1, 14'(cyc - 1)}) begin
          miscompares++;
          $display("FAIL issue_cycle%0d: rd=%b addr=%0d, expected 1 %0d", cyc, mem_rd_o, mem_addr_o, cyc - 1);
        end
      end
      if (cyc == 5) begin
        vectors++;
        if (mem_rd_o !== 1'b0) begin miscompares++; $display("FAIL rd_stop: rd=%b, expected 0", mem_rd_o); end
      end
      if (cyc == 10) begin
        vectors++;
        if ({done_o, result_valid_o, result_class_o, result_total_o} !== {1'b0, 1'b1, 8'd9, 32'd3}) begin
          miscompares++;
          $display("FAIL last_result_cycle: done=%b valid=%b class=%0d total=%0d, expected 0 1 9 3",
                   done_o, result_valid_o, result_class_o, result_total_o);
        end
      end
      if (cyc == 11) begin
        vectors++;
        if ({done_o, busy_o} !== 2'b10) begin
          miscompares++;
          $display("FAIL done_cycle: done=%b busy=%b, expected 1 0", done_o, busy_o);
        end
      end
    end
    wait_done(20, 1'b0, got);
    vectors++;
    if ({got, error_o, result_total_o, result_ok_o, 32'(exp_q.size())} !== {1'b1, 1'b0, 32'd4, 32'd4, 32'd0}) begin
      miscompares++;
      $display("FAIL identity_end: done=%b err=%b total=%0d ok=%0d pending=%0d, expected 1 0 4 4 0",
               got, error_o, result_total_o, result_ok_o, exp_q.size());
    end
  endtask

  task automatic test_tie_zero;
    bit got;
    bit [69:0] v;
    v = '0;
    for (int ch = 0; ch < 4; ch++) begin v[ch*10+2] = 1'b1; v[(ch+3)*10+5] = 1'b1; end
    gen_sample(0, 8'd5, v);
    gen_sample(1, 8'hFF, 70'd0);
    gen_sample(2, 8'd3, label_votes(3));
    load_run(3, 1'b0);
    kick(3);
    wait_done(100, 1'b0, got);
    vectors++;
    if ({got, error_o, result_total_o, result_ok_o, 32'(exp_q.size())} !== {1'b1, 1'b0, 32'd3, 32'd1, 32'd0}) begin
      miscompares++;
      $display("FAIL tie_zero_end: done=%b err=%b total=%0d ok=%0d pending=%0d, expected 1 0 3 1 0",
               got, error_o, result_total_o, result_ok_o, exp_q.size());
    end
  endtask

  task automatic test_zero_count;
    load_run(0, 1'b0);
    kick(0);
    vectors++;
    if ({done_o, busy_o, mem_rd_o, result_total_o, result_ok_o, error_o} !== {3'b100, 64'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL zero_count: done=%b busy=%b rd=%b total=%0d ok=%0d, expected 1 0 0 0 0",
               done_o, busy_o, mem_rd_o, result_total_o, result_ok_o);
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if ({done_o, busy_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL zero_count_hold: done=%b busy=%b, expected 1 0", done_o, busy_o);
    end
  endtask

  task automatic test_timeout;
    for (int k = 0; k < 3; k++) gen_sample(k, 8'(k + 1), label_votes(k + 1));
    load_run(3, 1'b1);
    kick(3);
    // Issues occupy cycles 1..3, so draining starts in cycle 4 and the abort lands in cycle 20.
    for (int cyc = 2; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 19) begin
        vectors++;
        if ({done_o, busy_o} !== 2'b01) begin
          miscompares++;
          $display("FAIL timeout_early: cycle 19 done=%b busy=%b, expected 0 1", done_o, busy_o);
        end
      end
      if (cyc == 20) begin
        vectors++;
        if ({done_o, busy_o, error_o, result_total_o, result_ok_o} !== {3'b101, 32'd2, 32'd2}) begin
          miscompares++;
          $display("FAIL timeout: done=%b busy=%b err=%b total=%0d ok=%0d, expected 1 0 1 2 2",
                   done_o, busy_o, error_o, result_total_o, result_ok_o);
        end
      end
    end
    drop_last = 1'b0;
  endtask

  task automatic test_random_and_cke;
    bit got;
    int n;
    for (int r = 0; r < 4; r++) begin
      n = (r >= 2) ? 10 : $urandom_range(5, 20);
      if (r != 3) for (int k = 0; k < n; k++) begin
        bit [7:0] l;
        l = 8'($urandom_range(0, 9));
        gen_sample(k, l, rand_votes(l));
      end
      load_run(n, 1'b0);
      kick(n);
      wait_done(200, (r == 3), got);
      vectors++;
      if ({got, error_o, busy_o, result_total_o, result_ok_o, 32'(exp_q.size()), 32'(exp_addr), 32'(in_idx)} !==
          {1'b1, 1'b0, 1'b0, 32'(exp_total), 32'(exp_ok), 32'd0, 32'(n), 32'(n)}) begin
        miscompares++;
        $display("FAIL random_run%0d: done=%b err=%b total=%0d/%0d ok=%0d/%0d pending=%0d reads=%0d/%0d",
                 r, got, error_o, result_total_o, exp_total, result_ok_o, exp_ok, exp_q.size(), exp_addr, n);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    bit got;
    bit seen;
    for (int k = 0; k < 10; k++) gen_sample(k, 8'(k % 10), label_votes(k % 10));
    load_run(10, 1'b0);
    kick(10);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd_o && mem_addr_o == 14'd5) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL reach_addr5: address 5 never issued"); end
    #2 rst_ni = 1'b0;
    #1;
    vectors++;
    if ((|{busy_o, done_o, error_o, mem_rd_o, mem_addr_o, net_in_valid_o, net_in_user_o, net_in_data_o,
           result_valid_o, result_class_o, result_label_o, result_match_o, result_total_o, result_ok_o}) !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: outputs not zero (busy=%b rd=%b addr=%0d total=%0d)",
               busy_o, mem_rd_o, mem_addr_o, result_total_o);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) gen_sample(k, 8'(k + 4), label_votes(k + 4));
    load_run(4, 1'b0);
    kick(4);
    vectors++;
    if ({busy_o, mem_rd_o, mem_addr_o, result_total_o, result_ok_o} !== {2'b11, 14'd0, 64'd0}) begin
      miscompares++;
      $display("FAIL restart: busy=%b rd=%b addr=%0d total=%0d ok=%0d, expected 1 1 0 0 0",
               busy_o, mem_rd_o, mem_addr_o, result_total_o, result_ok_o);
    end
    wait_done(100, 1'b0, got);
    vectors++;
    if ({got, error_o, result_total_o, result_ok_o, 32'(exp_q.size())} !== {1'b1, 1'b0, 32'd4, 32'd4, 32'd0}) begin
      miscompares++;
      $display("FAIL restart_end: done=%b err=%b total=%0d ok=%0d pending=%0d, expected 1 0 4 4 0",
               got, error_o, result_total_o, result_ok_o, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_tie_zero();
    test_zero_count();
    test_timeout();
    test_random_and_cke();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
